// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, the "no register" code and
// the encoded length of each instruction class.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RNONE   = 4'hF;

   // Encoded size in bytes; zero marks an icode with no defined encoding.
   function automatic logic [3:0] instr_length(input logic [3:0] icode);
      case (icode)
         IHALT, INOP, IRET:              return 4'd1;
         IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:   return 4'd2;
         IJXX, ICALL:                    return 4'd9;
         IIRMOVQ, IRMMOVQ, IMRMOVQ:      return 4'd10;
         default:                        return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Instruction-in / byte-out bundle of the Y86-64 encoder. The slave view is
// the encoder itself; the master view is whoever feeds it and sinks bytes.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 64
);

   logic              load_en;
   logic [ADDR_W-1:0] load_addr;

   logic              in_valid;
   logic              in_ready;
   logic [3:0]        icode;
   logic [3:0]        ifun;
   logic [3:0]        rA;
   logic [3:0]        rB;
   logic [63:0]       valC;

   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [7:0]        out_data;

   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              done;
   logic              func_error;

   modport master (
      output load_en, load_addr, in_valid, icode, ifun, rA, rB, valC, out_ready,
      input  in_ready, out_valid, out_addr, out_data, pc, busy, done, func_error
   );

   modport slave (
      input  load_en, load_addr, in_valid, icode, ifun, rA, rB, valC, out_ready,
      output in_ready, out_valid, out_addr, out_data, pc, busy, done, func_error
   );

endinterface

// File: rtl/instr_len.sv
// Combinational length and legality decode for one Y86-64 instruction.
// Define INSTR_ENC_FUNC_CHECK_EN to also reject bad ifun / irmovq rA fields.
module instr_len
   import y86_pkg::*;
(
   input  logic [3:0] icode,
   input  logic [3:0] ifun,
   input  logic [3:0] rA,
   output logic [3:0] len,
   output logic       legal
);

   always_comb begin
      len   = instr_length(icode);
      legal = (len != 4'd0);
`ifdef INSTR_ENC_FUNC_CHECK_EN
      case (icode)
         IOPQ:          if (ifun > 4'd3) legal = 1'b0;
         IJXX, IRRMOVQ: if (ifun > 4'd6) legal = 1'b0;
         IIRMOVQ:       if (ifun != 4'd0 || rA != RNONE) legal = 1'b0;
         default:       if (ifun != 4'd0) legal = 1'b0;
      endcase
`endif
   end

`ifndef INSTR_ENC_FUNC_CHECK_EN
   logic unused_fields;
   assign unused_fields = ^{ifun, rA};
`endif

endmodule

// File: rtl/instr_encoder.sv
// Y86-64 instruction encoder: accepts decoded fields, streams the
// little-endian byte image to instruction memory one byte per handshake.
// Optional field checking is enabled by INSTR_ENC_FUNC_CHECK_EN (see instr_len).
module instr_encoder
   import y86_pkg::*;
#(
   parameter int unsigned ADDR_W = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   instr_encoder_if.slave  bus
);

   typedef enum logic {
      S_IDLE,
      S_EMIT
   } state_e;

   state_e            state;
   logic [ADDR_W-1:0] pc_q;
   logic [3:0]        idx_q;
   logic [3:0]        len_q;
   logic              has_reg_q;
   logic [3:0]        icode_q;
   logic [3:0]        ifun_q;
   logic [3:0]        rA_q;
   logic [3:0]        rB_q;
   logic [63:0]       valC_q;
   logic              func_error_q;

   logic [3:0]        dec_len;
   logic              dec_legal;
   logic              last_byte;
   logic [3:0]        voff;
   logic [2:0]        vsel;
   logic [7:0]        cur_byte;

   instr_len u_len (
      .icode (bus.icode),
      .ifun  (bus.ifun),
      .rA    (bus.rA),
      .len   (dec_len),
      .legal (dec_legal)
   );

   assign last_byte = (idx_q == len_q - 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         pc_q         <= '0;
         idx_q        <= '0;
         len_q        <= '0;
         has_reg_q    <= 1'b0;
         icode_q      <= '0;
         ifun_q       <= '0;
         rA_q         <= '0;
         rB_q         <= '0;
         valC_q       <= '0;
         func_error_q <= 1'b0;
      end else begin
         func_error_q <= 1'b0;
         case (state)
            S_IDLE: begin
               // A load in the same cycle as acceptance sets the base for that instruction.
               if (bus.load_en)
                  pc_q <= bus.load_addr;
               if (bus.in_valid) begin
                  if (dec_legal) begin
                     icode_q   <= bus.icode;
                     ifun_q    <= bus.ifun;
                     rA_q      <= bus.rA;
                     rB_q      <= bus.rB;
                     valC_q    <= bus.valC;
                     len_q     <= dec_len;
                     has_reg_q <= (dec_len == 4'd2) || (dec_len == 4'd10);
                     idx_q     <= '0;
                     state     <= S_EMIT;
                  end else begin
                     func_error_q <= 1'b1;
                  end
               end
            end
            S_EMIT: begin
               if (bus.out_ready) begin
                  pc_q <= pc_q + ADDR_W'(1);
                  if (last_byte) begin
                     idx_q <= '0;
                     state <= S_IDLE;
                  end else begin
                     idx_q <= idx_q + 4'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Byte mux: header, optional register byte, then valC low byte first.
   always_comb begin
      voff = has_reg_q ? 4'd2 : 4'd1;
      vsel = 3'(idx_q - voff);
      if (idx_q == 4'd0)
         cur_byte = {icode_q, ifun_q};
      else if (has_reg_q && idx_q == 4'd1)
         cur_byte = {rA_q, rB_q};
      else
         cur_byte = valC_q[{vsel, 3'b000} +: 8];
   end

   assign bus.in_ready   = (state == S_IDLE);
   assign bus.busy       = (state == S_EMIT);
   assign bus.out_valid  = (state == S_EMIT);
   assign bus.out_addr   = pc_q;
   assign bus.out_data   = cur_byte;
   assign bus.pc         = pc_q;
   assign bus.done       = (state == S_EMIT) && bus.out_ready && last_byte;
   assign bus.func_error = func_error_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios with literal byte images, then
// randomized traffic checked every cycle against a queue-based byte model.
module tb_instr_encoder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_W(64)) bus ();

   instr_encoder #(.ADDR_W(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec  = 0;
   int n_miss = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   logic [63:0] m_pc = '0;
   logic [7:0]  m_q[$];
   bit          m_err = 1'b0;

   typedef struct packed {
      logic [63:0] addr;
      logic [7:0]  data;
      logic        done;
   } hs_t;
   hs_t         log_q[$];
   logic [7:0]  exp_q[$];

   function automatic int ilen(logic [3:0] ic);
      case (ic)
         4'h0, 4'h1, 4'h9:       return 1;
         4'h2, 4'h6, 4'hA, 4'hB: return 2;
         4'h7, 4'h8:             return 9;
         4'h3, 4'h4, 4'h5:       return 10;
         default:                return 0;
      endcase
   endfunction

   function automatic bit legal(logic [3:0] ic, logic [3:0] fn, logic [3:0] ra);
      if (ilen(ic) == 0) return 1'b0;
`ifdef INSTR_ENC_FUNC_CHECK_EN
      if (ic == 4'h6) return fn <= 4'd3;
      if (ic == 4'h7 || ic == 4'h2) return fn <= 4'd6;
      if (ic == 4'h3) return (fn == 4'd0) && (ra == 4'hF);
      return fn == 4'd0;
`else
      return (fn == fn) && (ra == ra);
`endif
   endfunction

   function automatic void push_image(logic [3:0] ic, logic [3:0] fn, logic [3:0] ra,
                                      logic [3:0] rb, logic [63:0] vc);
      int n;
      n = ilen(ic);
      m_q.push_back({ic, fn});
      if (n == 2 || n == 10) m_q.push_back({ra, rb});
      if (n >= 9)
         for (int i = 0; i < 8; i++) m_q.push_back(vc[8*i +: 8]);
   endfunction

   // Compare at negedge (inputs stable since posedge+1), then advance the model
   // with the handshake the coming posedge will perform.
   always @(negedge clk) begin
      bit e_busy;
      bit e_done;
      bit nerr;
      if (!rst_n) begin
         m_pc  = '0;
         m_q.delete();
         m_err = 1'b0;
      end
      e_busy = (m_q.size() != 0);
      e_done = e_busy && bus.out_ready && (m_q.size() == 1);
      chk("in_ready",   64'(bus.in_ready),   64'(!e_busy));
      chk("busy",       64'(bus.busy),       64'(e_busy));
      chk("out_valid",  64'(bus.out_valid),  64'(e_busy));
      chk("pc",         bus.pc,              m_pc);
      chk("done",       64'(bus.done),       64'(e_done));
      chk("func_error", 64'(bus.func_error), 64'(m_err));
      if (e_busy) begin
         chk("out_addr", bus.out_addr,        m_pc);
         chk("out_data", 64'(bus.out_data),   64'(m_q[0]));
      end
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready)
            log_q.push_back({bus.out_addr, bus.out_data, bus.done});
         nerr = 1'b0;
         if (e_busy) begin
            if (bus.out_ready) begin
               void'(m_q.pop_front());
               m_pc = m_pc + 64'd1;
            end
         end else begin
            if (bus.load_en) m_pc = bus.load_addr;
            if (bus.in_valid) begin
               if (legal(bus.icode, bus.ifun, bus.rA))
                  push_image(bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC);
               else
                  nerr = 1'b1;
            end
         end
         m_err = nerr;
      end
   end

   // ---------------- directed helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(int budget, bit toggle);
      int k;
      k = 0;
      while (bus.busy && k < budget) begin
         if (toggle) bus.out_ready = ~bus.out_ready;
         cyc();
         k++;
      end
      chk("idle_timeout", 64'(bus.busy), 64'd0);
   endtask

   function automatic void check_log(string nm, logic [63:0] base);
      chk({nm, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         chk({nm, "_addr"}, log_q[i].addr,       base + 64'(i));
         chk({nm, "_data"}, 64'(log_q[i].data),  64'(exp_q[i]));
         chk({nm, "_done"}, 64'(log_q[i].done),  64'(i == exp_q.size() - 1));
      end
   endfunction

   task automatic present(logic [3:0] ic, logic [3:0] fn, logic [3:0] ra,
                          logic [3:0] rb, logic [63:0] vc);
      bus.icode = ic; bus.ifun = fn; bus.rA = ra; bus.rB = rb; bus.valC = vc;
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      bus.load_en = 1'b0; bus.load_addr = '0; bus.in_valid = 1'b0;
      bus.icode = '0; bus.ifun = '0; bus.rA = '0; bus.rB = '0; bus.valC = '0;
      bus.out_ready = 1'b1;

      // reset state
      repeat (2) cyc();
      chk("rst_pc",       bus.pc,                64'd0);
      chk("rst_valid",    64'(bus.out_valid),    64'd0);
      chk("rst_busy",     64'(bus.busy),         64'd0);
      chk("rst_data",     64'(bus.out_data),     64'd0);
      chk("rst_in_ready", 64'(bus.in_ready),     64'd1);
      rst_n = 1'b1;
      cyc();

      // irmovq-shaped 10-byte image at 0x100
      log_q.delete();
      bus.load_en = 1'b1; bus.load_addr = 64'h100;
      cyc();
      bus.load_en = 1'b0;
      chk("load_pc", bus.pc, 64'h100);
      present(4'h3, 4'h0, 4'hF, 4'h2, 64'h0807060504030201);
      chk("acc_busy", 64'(bus.busy), 64'd1);
      wait_idle(30, 1'b0);
      exp_q = '{8'h30, 8'hF2, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      check_log("irmov", 64'h100);
      chk("irmov_pc", bus.pc, 64'h10A);

      // halt: single byte, busy for one cycle
      log_q.delete();
      present(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
      chk("halt_busy1", 64'(bus.busy), 64'd1);
      cyc();
      chk("halt_busy2", 64'(bus.busy), 64'd0);
      exp_q = '{8'h00};
      check_log("halt", 64'h10A);
      chk("halt_pc", bus.pc, 64'h10B);

      // jXX with out_ready toggling
      log_q.delete();
      bus.out_ready = 1'b0;
      present(4'h7, 4'h3, 4'h0, 4'h0, 64'h40);
      wait_idle(40, 1'b1);
      bus.out_ready = 1'b1;
      exp_q = '{8'h73, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      check_log("jxx", 64'h10B);
      chk("jxx_pc", bus.pc, 64'h114);

      // invalid icode
      log_q.delete();
      present(4'hD, 4'h0, 4'h0, 4'h0, 64'd0);
      chk("inv_err",   64'(bus.func_error), 64'd1);
      chk("inv_valid", 64'(bus.out_valid),  64'd0);
      cyc();
      chk("inv_err_clr", 64'(bus.func_error), 64'd0);
      chk("inv_pc",      bus.pc,              64'h114);
      chk("inv_log",     64'(log_q.size()),   64'd0);

      // opq with ifun 5: rejected only when field checking is built in
      present(4'h6, 4'h5, 4'h1, 4'h2, 64'd0);
`ifdef INSTR_ENC_FUNC_CHECK_EN
      chk("opq5_err", 64'(bus.func_error), 64'd1);
      cyc();
      chk("opq5_log", 64'(log_q.size()), 64'd0);
      chk("opq5_pc",  bus.pc,            64'h114);
`else
      chk("opq5_err", 64'(bus.func_error), 64'd0);
      wait_idle(10, 1'b0);
      exp_q = '{8'h65, 8'h12};
      check_log("opq5", 64'h114);
      chk("opq5_pc", bus.pc, 64'h116);
`endif

      // pc wrap, load and accept in the same cycle
      log_q.delete();
      bus.load_en = 1'b1; bus.load_addr = '1;
      present(4'h6, 4'h0, 4'h3, 4'h4, 64'd0);
      bus.load_en = 1'b0;
      wait_idle(10, 1'b0);
      exp_q = '{8'h60, 8'h34};
      check_log("wrap", 64'hFFFF_FFFF_FFFF_FFFF);
      chk("wrap_pc", bus.pc, 64'd1);

      // reset mid-emit, load during emit ignored
      log_q.delete();
      bus.load_en = 1'b1; bus.load_addr = 64'h200;
      cyc();
      bus.load_en = 1'b0;
      present(4'h3, 4'h0, 4'hF, 4'h1, 64'h1122334455667788);
      bus.load_en = 1'b1; bus.load_addr = 64'h999;
      repeat (3) cyc();
      chk("emit_load_pc", bus.pc, 64'h203);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_pc",    bus.pc,             64'd0);
      chk("midrst_busy",  64'(bus.busy),      64'd0);
      chk("midrst_log",   64'(log_q.size()),  64'd3);
      for (int i = 0; i < log_q.size(); i++)
         chk("midrst_nodone", 64'(log_q[i].done), 64'd0);
      bus.load_en = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();

      // randomized traffic, checked by the per-cycle model
      for (int n = 0; n < 4000; n++) begin
         bus.in_valid  = ($urandom % 3 == 0);
         bus.icode     = 4'($urandom);
         bus.ifun      = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom % 4);
         bus.rA        = ($urandom % 2 == 0) ? 4'hF : 4'($urandom);
         bus.rB        = 4'($urandom);
         bus.valC      = {$urandom, $urandom};
         bus.load_en   = ($urandom % 10 == 0);
         bus.load_addr = ($urandom % 2 == 0) ? {32'hFFFF_FFFF, $urandom | 32'hFFFF_FFF0}
                                             : {$urandom, $urandom};
         bus.out_ready = ($urandom % 4 != 0);
         rst_n         = ($urandom % 700 != 0);
         cyc();
      end
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      bus.load_en = 1'b0;
      bus.out_ready = 1'b1;
      repeat (15) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter: ADDR_W, 64, width of byte write address / program counter.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: load_en  in  1, load_addr  in  ADDR_W -- set write base address.
REQ-005 SHALL have ports: in_valid  in  1, in_ready  out  1 -- instruction handshake.
REQ-006 SHALL have ports: icode  in  4, ifun  in  4, rA  in  4, rB  in  4, valC  in  64 -- instruction fields.
REQ-007 SHALL have ports: out_valid  out  1, out_ready  in  1, out_addr  out  ADDR_W, out_data  out  8 -- byte write stream to instruction memory.
REQ-008 SHALL have ports: pc  out  ADDR_W (next write address), busy  out  1, done  out  1 (instruction fully emitted), func_error  out  1 (instruction rejected).

Function
REQ-009 SHALL be the Y86-64 instruction encoder: fields in, little-endian byte image out, exact inverse of fetch decode.
REQ-010 SHALL use lengths: icode 0,1,9 -> 1 byte; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10; icode C..F invalid.
REQ-011 SHALL emit byte0={icode,ifun}; for 2/10-byte forms byte1={rA,rB}; then valC[7:0] first through valC[63:56].
REQ-012 SHALL implement FSM IDLE/EMIT; in_ready=1 only in IDLE; busy=1 only in EMIT.
REQ-013 SHALL, on in_valid&&in_ready with valid icode, latch all fields, clear byte index, enter EMIT next cycle.
REQ-014 SHALL, on invalid icode in IDLE, stay IDLE, pulse func_error one cycle, leave pc unchanged, emit nothing.
REQ-015 SHALL in EMIT drive out_valid=1, out_addr=pc, out_data=current byte; first byte valid one cycle after acceptance.
REQ-016 SHALL hold out_data/out_addr stable while out_valid&&!out_ready.
REQ-017 SHALL on out_valid&&out_ready increment pc and byte index; on last byte return to IDLE and pulse done one cycle with it.
REQ-018 SHALL wrap pc modulo 2^ADDR_W without error.
REQ-019 SHALL accept load_en only in IDLE (pc<=load_addr); load_en in EMIT ignored; load_en and in_valid together in IDLE: load takes effect, instruction accepted same cycle, its bytes start at load_addr.
REQ-020 SHALL sustain one byte per cycle with out_ready held high; next instruction acceptable the cycle after done.

Reset
REQ-021 SHALL on rst_n low immediately force: IDLE, pc=0, byte index=0, latched fields=0, out_valid=0, out_data=0, done=0, func_error=0, busy=0.
REQ-022 SHALL on reset mid-EMIT discard remaining bytes; no done pulse.

Configuration
REQ-023 SHALL honour macro INSTR_ENC_FUNC_CHECK_EN.
REQ-024 SHALL, with macro defined, also reject (as REQ-014) opq ifun>3, jXX/cmov ifun>6, any other icode with ifun!=0, and rA!=F for irmovq; without it, only icode C..F are rejected and fields pass through unchecked.

Structure
REQ-025 SHALL take icode constants (IHALT..IPOPQ), RNONE=4'hF and instruction-length function from shared package y86_pkg.
REQ-026 SHALL place length/legality decode in combinational sub-module instr_len; FSM, counters, byte mux in instr_encoder.

Verification
REQ-027 SHALL cover: reset, load 0x100, icode=3 ifun=0 rA=F rB=2 valC=0x0807060504030201, out_ready=1 -> bytes 30,F2,01..08 at 0x100..0x109, done with last byte, pc=0x10A.
REQ-028 SHALL cover: icode=0 -> single byte 00, pc+1, busy one cycle only.
REQ-029 SHALL cover: icode=7 ifun=3 valC=0x40, out_ready toggled 1/0 -> 9 bytes 73,40,00x7, stable data during stalls, 9 handshakes total.
REQ-030 SHALL cover: icode=D -> func_error one cycle, no out_valid, pc unchanged; with macro, icode=6 ifun=5 also rejected, without it emits 65,rArB.
REQ-031 SHALL cover: pc loaded 2^64-1, icode=6 ifun=0 -> bytes at FFFF_FFFF_FFFF_FFFF then 0, pc=1.
REQ-032 SHALL cover: rst_n low after 3rd byte of 10-byte instruction -> out_valid 0 immediately, pc=0, no done; load_en during EMIT ignored.
